surf6_fwu_block_writer: RTL

SURF6_FWU_BLOCK_WRITER -- requirements
Module: surf6_fwu_block_writer

---
 rtl/surf6_fwu_pkg.sv | 20 ++
 rtl/surf6_fwu_packer.sv | 71 +++++++
 rtl/surf6_fwu_block_writer.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/surf6_fwu_pkg.sv
// ---------------------------------------------------------------------------
// surf6_fwu_pkg: shared state type and default address width for the FWU writer.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package surf6_fwu_pkg;

  localparam int FWU_ADDR_W_DEFAULT = 10;

  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_FLUSH = 2'd1,
    ST_MARK  = 2'd2,
    ST_WAIT  = 2'd3
  } fwu_state_e;

endpackage

`default_nettype wire

// File: rtl/surf6_fwu_packer.sv
// ---------------------------------------------------------------------------
// surf6_fwu_packer: little-endian byte-to-word packer with zero-padded flush.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module surf6_fwu_packer (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        push_i,
  input  logic [7:0]  dat_i,
  input  logic        flush_i,
  output logic        word_done_o,
  output logic        pending_o,
  output logic        wr_o,
  output logic [31:0] dat_o
);

  logic [1:0]  cnt_q, cnt_d;
  logic [23:0] sr_q, sr_d;
  logic        wr_q, wr_d;
  logic [31:0] dat_q, dat_d;

  assign pending_o   = (cnt_q != 2'd0);
  assign word_done_o = (flush_i && pending_o) || (push_i && (cnt_q == 2'd3));
  assign wr_o        = wr_q;
  assign dat_o       = dat_q;

  always_comb begin
    cnt_d = cnt_q;
    sr_d  = sr_q;
    wr_d  = 1'b0;
    dat_d = dat_q;
    if (flush_i && pending_o) begin
      // Unfilled lanes are already zero because sr is cleared per word.
      wr_d  = 1'b1;
      dat_d = {8'h00, sr_q};
      cnt_d = 2'd0;
      sr_d  = '0;
    end else if (push_i) begin
      case (cnt_q)
        2'd0: sr_d[7:0]   = dat_i;
        2'd1: sr_d[15:8]  = dat_i;
        2'd2: sr_d[23:16] = dat_i;
        default: begin
          wr_d  = 1'b1;
          dat_d = {dat_i, sr_q};
          sr_d  = '0;
        end
      endcase
      cnt_d = cnt_q + 2'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= 2'd0;
      sr_q  <= '0;
      wr_q  <= 1'b0;
      dat_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      sr_q  <= sr_d;
      wr_q  <= wr_d;
      dat_q <= dat_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/surf6_fwu_block_writer.sv
// ---------------------------------------------------------------------------
// surf6_fwu_block_writer: packs firmware bytes into a two-bank BRAM and hands
// closed banks to the PS. Optional FWU_BYTE_COUNT_EN adds fw_len_o. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module surf6_fwu_block_writer
  import surf6_fwu_pkg::*;
#(
  parameter int ADDR_W = FWU_ADDR_W_DEFAULT
) (
  input  logic              sysclk_i,
  input  logic              sysrst_n_i,
  input  logic [7:0]        fw_dat_i,
  input  logic              fw_valid_i,
  output logic              fw_ready_o,
  input  logic              fw_mark_req_i,
  input  logic              fw_bank_done_i,
  output logic              bram_we_o,
  output logic [ADDR_W:0]   bram_addr_o,
  output logic [31:0]       bram_dat_o,
  output logic              fw_wr_o,
  output logic              fw_mark_o,
  output logic              fw_bank_o,
  output logic              fw_err_o
`ifdef FWU_BYTE_COUNT_EN
  ,
  output logic [ADDR_W+2:0] fw_len_o
`endif
);

  localparam logic [ADDR_W:0] PTR_ONE = 1;

  fwu_state_e      state_q, state_d;
  logic [ADDR_W:0] ptr_q, ptr_d;
  logic [ADDR_W:0] addr_q, addr_d;
  logic            bank_q, bank_d;
  logic [1:0]      busy_q, busy_d;
  logic            done_ptr_q, done_ptr_d;
  logic            err_q, err_d;

  logic byte_acc, flush, done_ok, has_data;
  logic pk_word_done, pk_pending, pk_wr;

  // ptr msb set means every word of the bank has been claimed.
  assign fw_ready_o = sysrst_n_i && (state_q == ST_FILL) && !ptr_q[ADDR_W] && !fw_mark_req_i;
  assign byte_acc   = fw_valid_i && fw_ready_o;
  assign flush      = (state_q == ST_FILL) && fw_mark_req_i && pk_pending;
  assign has_data   = (ptr_q != '0) || pk_pending;
  assign done_ok    = fw_bank_done_i && busy_q[done_ptr_q];

  surf6_fwu_packer u_packer (
    .clk_i       (sysclk_i),
    .rst_n_i     (sysrst_n_i),
    .push_i      (byte_acc),
    .dat_i       (fw_dat_i),
    .flush_i     (flush),
    .word_done_o (pk_word_done),
    .pending_o   (pk_pending),
    .wr_o        (pk_wr),
    .dat_o       (bram_dat_o)
  );

  assign bram_we_o   = pk_wr;
  assign fw_wr_o     = pk_wr;
  assign bram_addr_o = addr_q;
  assign fw_mark_o   = (state_q == ST_MARK);
  assign fw_bank_o   = bank_q;
  assign fw_err_o    = err_q;

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    addr_d     = addr_q;
    bank_d     = bank_q;
    busy_d     = busy_q;
    done_ptr_d = done_ptr_q;
    err_d      = err_q;

    if (done_ok) begin
      busy_d[done_ptr_q] = 1'b0;
      done_ptr_d         = ~done_ptr_q;
    end else if (fw_bank_done_i) begin
      err_d = 1'b1;
    end

    // Address is captured with the completing byte so the pointer already
    // reflects the word in flight when fullness is evaluated next cycle.
    if (pk_word_done) begin
      addr_d = {bank_q, ptr_q[ADDR_W-1:0]};
      ptr_d  = ptr_q + PTR_ONE;
    end

    case (state_q)
      ST_FILL: begin
        if (fw_mark_req_i) begin
          if (!has_data)       err_d   = 1'b1;
          else if (pk_pending) state_d = ST_FLUSH;
          else                 state_d = ST_MARK;
        end
      end
      ST_FLUSH: begin
        if (fw_mark_req_i) err_d = 1'b1;
        state_d = ST_MARK;
      end
      ST_MARK: begin
        if (fw_mark_req_i) err_d = 1'b1;
        busy_d[bank_q] = 1'b1;
        bank_d         = ~bank_q;
        ptr_d          = '0;
        state_d        = busy_d[~bank_q] ? ST_WAIT : ST_FILL;
      end
      ST_WAIT: begin
        if (fw_mark_req_i) err_d = 1'b1;
        if (!busy_d[bank_q]) state_d = ST_FILL;
      end
      default: state_d = ST_FILL;
    endcase
  end

  always_ff @(posedge sysclk_i or negedge sysrst_n_i) begin
    if (!sysrst_n_i) begin
      state_q    <= ST_FILL;
      ptr_q      <= '0;
      addr_q     <= '0;
      bank_q     <= 1'b0;
      busy_q     <= 2'b00;
      done_ptr_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      addr_q     <= addr_d;
      bank_q     <= bank_d;
      busy_q     <= busy_d;
      done_ptr_q <= done_ptr_d;
      err_q      <= err_d;
    end
  end

`ifdef FWU_BYTE_COUNT_EN
  logic [ADDR_W+2:0] blk_cnt_q, blk_cnt_d;
  logic [ADDR_W+2:0] len_q, len_d;
  localparam logic [ADDR_W+2:0] CNT_ONE = 1;

  always_comb begin
    blk_cnt_d = blk_cnt_q;
    len_d     = len_q;
    if (state_q == ST_MARK) begin
      len_d     = blk_cnt_q;
      blk_cnt_d = '0;
    end else if (byte_acc) begin
      blk_cnt_d = blk_cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge sysclk_i or negedge sysrst_n_i) begin
    if (!sysrst_n_i) begin
      blk_cnt_q <= '0;
      len_q     <= '0;
    end else begin
      blk_cnt_q <= blk_cnt_d;
      len_q     <= len_d;
    end
  end

  assign fw_len_o = len_q;
`endif

endmodule

`default_nettype wire
